// File: rtl/pixel_writeback_pkg.sv
// Shared constants and state type for the pixel transfer / writeback path.
package pixel_writeback_pkg;

  localparam int unsigned DefRows   = 7;
  localparam int unsigned DefCols   = 7;
  localparam int unsigned DefPixW   = 12;
  localparam int unsigned DefRowW   = 9;
  localparam int unsigned DefColW   = 8;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned FillW     = 3;

  typedef enum logic [0:0] {
    StIdle,
    StRecv
  } pw_state_e;

endpackage

// File: rtl/pixel_writeback_if.sv
// Strobed pixel input stream plus BRAM write port and status of pixel_writeback.
interface pixel_writeback_if
  import pixel_writeback_pkg::*;
#(
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned ROW_W = DefRowW,
  parameter int unsigned COL_W = DefColW
) ();

  logic             strobe;
  logic [PIX_W-1:0] pixel_in;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             wr_ready;
  logic             err_clr;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [PIX_W-1:0] wr_data;
  logic             frame_done;
  logic             seq_err;
  logic             overflow;
  logic [FillW-1:0] fill;

  modport master (
    output strobe, pixel_in, pix_row, pix_col, wr_ready, err_clr,
    input  wr_en, wr_row, wr_col, wr_data, frame_done, seq_err, overflow, fill
  );

  modport slave (
    input  strobe, pixel_in, pix_row, pix_col, wr_ready, err_clr,
    output wr_en, wr_row, wr_col, wr_data, frame_done, seq_err, overflow, fill
  );

endinterface

// File: rtl/pw_fifo.sv
// Small first-word-fall-through FIFO; push on a full FIFO is taken only alongside a pop.
module pw_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pixel_writeback.sv
// Writes the masked pixel stream into the output frame BRAM, buffering write stalls in a
// 4-entry FIFO, checking raster order and pulsing frame_done with the last pixel's write.
module pixel_writeback
  import pixel_writeback_pkg::*;
#(
  parameter int unsigned ROWS  = DefRows,
  parameter int unsigned COLS  = DefCols,
  parameter int unsigned PIX_W = DefPixW,
  parameter int unsigned ROW_W = DefRowW,
  parameter int unsigned COL_W = DefColW
) (
  input logic         Clock,
  input logic         Resetn,
  pixel_writeback_if.slave bus
);

  localparam int unsigned EntW = ROW_W + COL_W + PIX_W;
  localparam logic [ROW_W-1:0] LastRow = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LastCol = COL_W'(COLS - 1);

  pw_state_e        state_q, state_d;
  logic [ROW_W-1:0] exp_row_q, exp_row_d;
  logic [COL_W-1:0] exp_col_q, exp_col_d;
  logic             seq_err_q, seq_err_d;
  logic             overflow_q, overflow_d;
  logic             wr_en_q, frame_done_q;
  logic [ROW_W-1:0] wr_row_q;
  logic [COL_W-1:0] wr_col_q;
  logic [PIX_W-1:0] wr_data_q;

  logic             accept, seq_set, ovf_set, push, pop;
  logic             fifo_full, fifo_empty;
  logic [EntW-1:0]  fifo_rdata;
  logic [FillW-1:0] fifo_count;
  logic [ROW_W-1:0] head_row, nxt_row;
  logic [COL_W-1:0] head_col, nxt_col;
  logic [PIX_W-1:0] head_pix;
  logic             nxt_wrap, pos_match, at_origin;

  pw_fifo #(
    .Depth (FifoDepth),
    .Width (EntW),
    .CntW  (FillW)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Resetn),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.pix_row, bus.pix_col, bus.pixel_in}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {head_row, head_col, head_pix} = fifo_rdata;

  assign pos_match = (bus.pix_row == exp_row_q) && (bus.pix_col == exp_col_q);
  assign at_origin = (bus.pix_row == '0) && (bus.pix_col == '0);
  assign pop       = !fifo_empty && bus.wr_ready;

  // Position following the received one; resyncing after an error uses the same path.
  always_comb begin
    nxt_row  = bus.pix_row;
    nxt_col  = bus.pix_col + COL_W'(1);
    nxt_wrap = 1'b0;
    if (bus.pix_col == LastCol) begin
      nxt_col = '0;
      if (bus.pix_row == LastRow) begin
        nxt_row  = '0;
        nxt_wrap = 1'b1;
      end else begin
        nxt_row = bus.pix_row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    exp_row_d = exp_row_q;
    exp_col_d = exp_col_q;
    accept    = 1'b0;
    seq_set   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.strobe) begin
          if (at_origin) begin
            accept    = 1'b1;
            exp_row_d = nxt_row;
            exp_col_d = nxt_col;
            state_d   = nxt_wrap ? StIdle : StRecv;
          end else begin
            seq_set = 1'b1;
          end
        end
      end
      StRecv: begin
        if (bus.strobe) begin
          accept    = 1'b1;
          seq_set   = !pos_match;
          exp_row_d = nxt_row;
          exp_col_d = nxt_col;
          if (nxt_wrap) state_d = StIdle;
        end
      end
    endcase
  end

  // Expected position advances even when the pixel itself is dropped for lack of space.
  assign push       = accept && (!fifo_full || pop);
  assign ovf_set    = accept && fifo_full && !pop;
  assign seq_err_d  = seq_set || (seq_err_q && !bus.err_clr);
  assign overflow_d = ovf_set || (overflow_q && !bus.err_clr);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= StIdle;
      exp_row_q    <= '0;
      exp_col_q    <= '0;
      seq_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      exp_row_q    <= exp_row_d;
      exp_col_q    <= exp_col_d;
      seq_err_q    <= seq_err_d;
      overflow_q   <= overflow_d;
      wr_en_q      <= pop;
      frame_done_q <= pop && (head_row == LastRow) && (head_col == LastCol);
      if (pop) begin
        wr_row_q  <= head_row;
        wr_col_q  <= head_col;
        wr_data_q <= head_pix;
      end
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.fill       = fifo_count;

endmodule
